// File: rtl/cpu_int_seq_if.sv
// System-bus bundle driven by the interrupt sequencer while it owns the bus.
interface cpu_int_seq_if #(
  parameter int ADDR_N = 16,
  parameter int DATA_N = 8
);
  logic [ADDR_N-1:0] bus_addr;
  logic              bus_we;
  logic [DATA_N-1:0] bus_wdata;
  logic [DATA_N-1:0] bus_rdata;
  logic              bus_ready;

  modport master (output bus_addr, bus_we, bus_wdata, input bus_rdata, bus_ready);
  modport slave  (input bus_addr, bus_we, bus_wdata, output bus_rdata, bus_ready);
endinterface

// File: rtl/cpu_int_seq.sv
// RESET/NMI/IRQ/BRK sequencer: arbitrates at instruction boundaries, pushes
// PC and P, fetches the vector, then loads the PC and sets the I flag.
module cpu_int_seq #(
  parameter int                       ADDR_N     = 16,
  parameter int                       DATA_N     = 8,
  parameter int                       IRQ_N      = 4,
  parameter logic [ADDR_N-DATA_N-1:0] STACK_PAGE = 8'h01,
  parameter logic [ADDR_N-1:0]        VEC_NMI    = 16'hFFFA,
  parameter logic [ADDR_N-1:0]        VEC_RST    = 16'hFFFC,
  parameter logic [ADDR_N-1:0]        VEC_IRQ    = 16'hFFFE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nmi_n,
  input  logic [IRQ_N-1:0]  irq_n,
  input  logic [IRQ_N-1:0]  irq_mask,
  input  logic              i_flag,
  input  logic              ins_boundary,
  input  logic              brk,
  input  logic [ADDR_N-1:0] pc,
  input  logic [DATA_N-1:0] p,
  input  logic [DATA_N-1:0] sp,
  output logic              busy,
  cpu_int_seq_if.master     bus,
  output logic              sp_dec,
  output logic              pc_load,
  output logic [ADDR_N-1:0] pc_val,
  output logic              set_i,
  output logic              done,
  output logic [1:0]        src,
  output logic [2:0]        irq_id
);

  typedef enum logic [2:0] {IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, LOAD} state_e;

  localparam logic [1:0] SRC_RST = 2'd0;
  localparam logic [1:0] SRC_NMI = 2'd1;
  localparam logic [1:0] SRC_IRQ = 2'd2;
  localparam logic [1:0] SRC_BRK = 2'd3;

  state_e            state_q, state_d;
  logic [1:0]        src_q;
  logic [2:0]        irq_id_q;
  logic              brk_q;
  logic [ADDR_N-1:0] pc_q;
  logic [DATA_N-1:0] p_q, sp_q, lo_q, hi_q;
  logic              nmi_prev_q, nmi_pend_q;

  logic [IRQ_N-1:0]  irq_act;
  logic              irq_pend;
  logic [2:0]        irq_sel;
  logic              entry, push_st, hijack, nmi_clr;
  logic [1:0]        src_eff;
  logic [ADDR_N-1:0] vec;
  logic [DATA_N-1:0] p_push;

  always_comb begin
    irq_act  = ~irq_n & irq_mask;
    irq_pend = (|irq_act) & ~i_flag;
    irq_sel  = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (irq_act[i]) irq_sel = 3'(i);
    end
  end

  assign entry   = ins_boundary && (nmi_pend_q || irq_pend || brk);
  assign push_st = (state_q == PUSH_H) || (state_q == PUSH_L) || (state_q == PUSH_P);

  // A pending NMI takes over an IRQ/BRK sequence until its low vector byte is fetched.
  assign hijack  = nmi_pend_q && (src_q == SRC_IRQ || src_q == SRC_BRK) &&
                   (push_st || state_q == VEC_L);
  assign src_eff = hijack ? SRC_NMI : src_q;
  assign nmi_clr = (state_q == VEC_L) && bus.bus_ready && (src_eff == SRC_NMI);

  always_comb begin
    case (src_eff)
      SRC_RST: vec = VEC_RST;
      SRC_NMI: vec = VEC_NMI;
      default: vec = VEC_IRQ;
    endcase
  end

  always_comb begin
    p_push    = p_q | DATA_N'(8'h20);
    p_push[4] = brk_q;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (entry) state_d = PUSH_H;
      PUSH_H:  if (bus.bus_ready) state_d = PUSH_L;
      PUSH_L:  if (bus.bus_ready) state_d = PUSH_P;
      PUSH_P:  if (bus.bus_ready) state_d = VEC_L;
      VEC_L:   if (bus.bus_ready) state_d = VEC_H;
      VEC_H:   if (bus.bus_ready) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) state_d = PUSH_H;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_n;
      if (nmi_prev_q && !nmi_n) nmi_pend_q <= 1'b1;
      else if (nmi_clr)         nmi_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= SRC_RST;
      irq_id_q <= '0;
      brk_q    <= 1'b0;
      sp_q     <= sp;
    end else if (state_q == IDLE) begin
      if (entry) begin
        src_q    <= nmi_pend_q ? SRC_NMI : (irq_pend ? SRC_IRQ : SRC_BRK);
        irq_id_q <= (!nmi_pend_q && irq_pend) ? irq_sel : 3'd0;
        brk_q    <= !nmi_pend_q && !irq_pend;
        pc_q     <= pc;
        p_q      <= p;
        sp_q     <= sp;
      end
    end else begin
      src_q <= src_eff;
      if (push_st && bus.bus_ready) sp_q <= sp_q - 1'b1;
      if (state_q == VEC_L && bus.bus_ready) lo_q <= bus.bus_rdata;
      if (state_q == VEC_H && bus.bus_ready) hi_q <= bus.bus_rdata;
    end
  end

  always_comb begin
    busy          = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_we    = 1'b0;
    bus.bus_wdata = '0;
    sp_dec        = 1'b0;
    pc_load       = 1'b0;
    pc_val        = '0;
    set_i         = 1'b0;
    done          = 1'b0;
    src           = src_q;
    irq_id        = irq_id_q;
    case (state_q)
      PUSH_H, PUSH_L, PUSH_P: begin
        busy         = 1'b1;
        bus.bus_addr = {STACK_PAGE, sp_q};
        bus.bus_we   = (src_q != SRC_RST);
        sp_dec       = bus.bus_ready;
        if (state_q == PUSH_H)      bus.bus_wdata = pc_q[ADDR_N-1 -: DATA_N];
        else if (state_q == PUSH_L) bus.bus_wdata = pc_q[DATA_N-1:0];
        else                        bus.bus_wdata = p_push;
      end
      VEC_L: begin
        busy         = 1'b1;
        bus.bus_addr = vec;
      end
      VEC_H: begin
        busy         = 1'b1;
        bus.bus_addr = vec + ADDR_N'(1);
      end
      LOAD: begin
        busy    = 1'b1;
        pc_load = 1'b1;
        pc_val  = ADDR_N'({hi_q, lo_q});
        set_i   = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
    // Reset silences the bus at once, including a push already in flight.
    if (reset) begin
      busy          = 1'b0;
      bus.bus_addr  = '0;
      bus.bus_we    = 1'b0;
      bus.bus_wdata = '0;
      sp_dec        = 1'b0;
      pc_load       = 1'b0;
      pc_val        = '0;
      set_i         = 1'b0;
      done          = 1'b0;
      src           = SRC_RST;
      irq_id        = '0;
    end
  end

endmodule

// File: tb/tb_cpu_int_seq.sv
// Directed bench for cpu_int_seq: table of entry scenarios plus hand-written
// reset, wait-state and reset-abort sequences.
module tb_cpu_int_seq;

  logic        clk = 1'b0;
  logic        reset, nmi_n, i_flag, ins_boundary, brk, rdy;
  logic [3:0]  irq_n, irq_mask;
  logic [15:0] pc;
  logic [7:0]  p, sp;
  logic        busy, sp_dec, pc_load, set_i, done;
  logic [15:0] pc_val;
  logic [1:0]  src;
  logic [2:0]  irq_id;

  int checks = 0;
  int failures = 0;

  cpu_int_seq_if #(.ADDR_N(16), .DATA_N(8)) bus_if ();

  cpu_int_seq dut (
    .clk(clk), .reset(reset), .nmi_n(nmi_n), .irq_n(irq_n), .irq_mask(irq_mask),
    .i_flag(i_flag), .ins_boundary(ins_boundary), .brk(brk), .pc(pc), .p(p), .sp(sp),
    .busy(busy), .bus(bus_if), .sp_dec(sp_dec), .pc_load(pc_load), .pc_val(pc_val),
    .set_i(set_i), .done(done), .src(src), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memrd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h11;
      16'hFFFB: return 8'h22;
      16'hFFFC: return 8'h00;
      16'hFFFD: return 8'hC0;
      16'hFFFE: return 8'h78;
      16'hFFFF: return 8'h56;
      default:  return 8'hEE;
    endcase
  endfunction

  always_comb bus_if.bus_rdata = memrd(bus_if.bus_addr);
  assign bus_if.bus_ready = rdy;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  p, sp;
    logic [3:0]  irqn, mask;
    logic        ifl, brk, nmi_pre;
    int          nmi_at;
    logic        we;
    logic [15:0] a0, a1, a2;
    logic [7:0]  d0, d1, d2;
    logic [15:0] vec, pcv;
    logic [1:0]  src;
    logic        chk_id;
    logic [2:0]  id;
  } vec_t;

  vec_t vt[5];
  vec_t rst_v, rst_v2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata, sp_dec,
                pc_load, pc_val, set_i, done, src, irq_id});
  endfunction

  task automatic enter(input vec_t v);
    @(negedge clk);
    pc = v.pc; p = v.p; sp = v.sp; irq_n = v.irqn; irq_mask = v.mask;
    i_flag = v.ifl; brk = v.brk;
    if (v.nmi_pre) begin
      nmi_n = 1'b0;
      @(posedge clk); #1;
      nmi_n = 1'b1;
      @(negedge clk);
    end
    ins_boundary = 1'b1;
    @(posedge clk); #1;
    ins_boundary = 1'b0;
    brk = 1'b0;
  endtask

  // Cycle 1 is the first bus cycle; LOAD in cycle 6, idle in cycle 7.
  task automatic run_body(input string tag, input vec_t v);
    logic [15:0] a[3];
    logic [7:0]  d[3];
    a[0] = v.a0; a[1] = v.a1; a[2] = v.a2;
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); #1;
      if (k <= 3)
        chk($sformatf("%s_push%0d", tag, k),
            64'({bus_if.bus_addr, bus_if.bus_we, (v.we ? bus_if.bus_wdata : 8'h00), sp_dec, busy}),
            64'({a[k-1], v.we, (v.we ? d[k-1] : 8'h00), 1'b1, 1'b1}));
      else if (k <= 5)
        chk($sformatf("%s_vec%0d", tag, k - 4),
            64'({bus_if.bus_addr, bus_if.bus_we, sp_dec, busy}),
            64'({v.vec + 16'(k - 4), 1'b0, 1'b0, 1'b1}));
      else if (k == 6) begin
        chk($sformatf("%s_load", tag), 64'({pc_load, set_i, done, pc_val, src}),
            64'({3'b111, v.pcv, v.src}));
        if (v.chk_id) chk($sformatf("%s_irq_id", tag), 64'(irq_id), 64'(v.id));
      end else
        chk($sformatf("%s_idle", tag), 64'({busy, done, pc_load}), 64'(0));
      if (k == v.nmi_at) nmi_n = 1'b0;
    end
    irq_n = 4'hF; i_flag = 1'b0;
  endtask

  initial begin
    vt[0] = '{16'h1234, 8'h81, 8'hFF, 4'b1011, 4'hF, 1'b0, 1'b0, 1'b0, -1, 1'b1,
              16'h01FF, 16'h01FE, 16'h01FD, 8'h12, 8'h34, 8'hA1, 16'hFFFE, 16'h5678,
              2'd2, 1'b1, 3'd2};
    vt[1] = '{16'h4000, 8'h95, 8'hFD, 4'b0000, 4'hF, 1'b1, 1'b1, 1'b0, -1, 1'b1,
              16'h01FD, 16'h01FC, 16'h01FB, 8'h40, 8'h00, 8'hB5, 16'hFFFE, 16'h5678,
              2'd3, 1'b0, 3'd0};
    vt[2] = '{16'hABCD, 8'h00, 8'h01, 4'b0100, 4'b1010, 1'b0, 1'b0, 1'b0, -1, 1'b1,
              16'h0101, 16'h0100, 16'h01FF, 8'hAB, 8'hCD, 8'h20, 16'hFFFE, 16'h5678,
              2'd2, 1'b1, 3'd1};
    vt[3] = '{16'h8001, 8'h04, 8'h80, 4'b0000, 4'hF, 1'b0, 1'b1, 1'b1, -1, 1'b1,
              16'h0180, 16'h017F, 16'h017E, 8'h80, 8'h01, 8'h24, 16'hFFFA, 16'h2211,
              2'd1, 1'b0, 3'd0};
    vt[4] = '{16'h2000, 8'h00, 8'hFF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 2, 1'b1,
              16'h01FF, 16'h01FE, 16'h01FD, 8'h20, 8'h00, 8'h30, 16'hFFFA, 16'h2211,
              2'd1, 1'b0, 3'd0};
    rst_v  = '{16'h0000, 8'h00, 8'hFD, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, -1, 1'b0,
               16'h01FD, 16'h01FC, 16'h01FB, 8'h00, 8'h00, 8'h00, 16'hFFFC, 16'hC000,
               2'd0, 1'b0, 3'd0};
    rst_v2 = rst_v;
    rst_v2.a0 = 16'h0140; rst_v2.a1 = 16'h013F; rst_v2.a2 = 16'h013E;

    reset = 1'b1; nmi_n = 1'b1; irq_n = 4'hF; irq_mask = 4'hF; i_flag = 1'b0;
    ins_boundary = 1'b0; brk = 1'b0; pc = 16'h0; p = 8'h0; sp = 8'hFD; rdy = 1'b1;

    // Power-up reset: two cycles of all-zero outputs, then the read-only reset sequence.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rst_hold%0d", c), all_outs(), 64'(0));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_body("rst", rst_v);

    // Masked IRQ without BRK, and a pending IRQ without a boundary: no entry.
    @(negedge clk);
    irq_n = 4'b0000; i_flag = 1'b1; ins_boundary = 1'b1;
    @(posedge clk); #1;
    ins_boundary = 1'b0;
    @(negedge clk); #1;
    chk("no_entry_masked", 64'(busy), 64'(0));
    i_flag = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("no_entry_noboundary", 64'(busy), 64'(0));
    irq_n = 4'hF;

    for (int i = 0; i < 5; i++) begin
      enter(vt[i]);
      run_body($sformatf("v%0d", i), vt[i]);
      if (vt[i].nmi_at >= 0) begin
        // nmi_n still low: the serviced edge must not re-enter.
        @(negedge clk);
        ins_boundary = 1'b1;
        @(posedge clk); #1;
        ins_boundary = 1'b0;
        @(negedge clk); #1;
        chk($sformatf("v%0d_no_reentry", i), 64'(busy), 64'(0));
        nmi_n = 1'b1;
      end
    end

    // Three wait states in PUSH_L stretch the sequence by three cycles.
    enter(vt[0]);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rdy = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
      #1;
      if (k == 1)
        chk("ws_push_h", 64'({bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata, sp_dec}),
            64'({16'h01FF, 1'b1, 8'h12, 1'b1}));
      else if (k <= 5)
        chk($sformatf("ws_push_l%0d", k),
            64'({bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata, sp_dec}),
            64'({16'h01FE, 1'b1, 8'h34, (k == 5)}));
      else if (k == 6)
        chk("ws_push_p", 64'({bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata, sp_dec}),
            64'({16'h01FD, 1'b1, 8'hA1, 1'b1}));
      else if (k <= 8)
        chk($sformatf("ws_vec%0d", k - 7), 64'({bus_if.bus_addr, bus_if.bus_we}),
            64'({16'hFFFE + 16'(k - 7), 1'b0}));
      else if (k == 9)
        chk("ws_load", 64'({done, pc_val, src}), 64'({1'b1, 16'h5678, 2'd2}));
      else
        chk("ws_idle", 64'(busy), 64'(0));
    end
    rdy = 1'b1;
    irq_n = 4'hF;

    // Reset in PUSH_P: the write is suppressed immediately, then a fresh reset sequence.
    enter(vt[0]);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; sp = 8'h40; irq_n = 4'hF;
    #1;
    chk("abort_same_cycle", all_outs(), 64'(0));
    @(negedge clk); #1;
    chk("abort_next_cycle", all_outs(), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    run_body("rst2", rst_v2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
